// File: rtl/kbd_pkg.sv
// Shared types for the key event decoder: event encodings, FIFO entry
// layout and the debounce/repeat FSM state set.
package kbd_pkg;

  localparam int KEY_W = 8;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'b00,
    EVT_RELEASE = 2'b01,
    EVT_REPEAT  = 2'b10
  } evt_type_e;

  typedef struct packed {
    evt_type_e          typ;
    logic [KEY_W-1:0]   code;
  } key_evt_t;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    REPEAT,
    REL_DB
  } kbd_state_e;

endpackage

// File: rtl/kbd_event_fifo.sv
// Synchronous event FIFO; a push into a full FIFO is accepted only when a
// pop frees the head slot in the same cycle.
module kbd_event_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  kbd_pkg::key_evt_t             din,
  input  logic                          pop,
  output kbd_pkg::key_evt_t             dout,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);
  import kbd_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);

  key_evt_t        mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero when empty so the outputs read 0 after reset.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// Debounces the keyboard key code and emits press/release/repeat events
// through a small FIFO with a valid/ready host interface.
module key_event_decoder #(
  parameter int KEY_W           = kbd_pkg::KEY_W,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_PERIOD   = 8,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [KEY_W-1:0]              key_code,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [1:0]                    evt_type,
  output logic [KEY_W-1:0]              evt_code,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_ovf
);
  import kbd_pkg::*;

  localparam int CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  kbd_state_e        state;
  logic [KEY_W-1:0]  key_q;
  logic [KEY_W-1:0]  cand;
  logic [CW-1:0]     cnt;
  logic [RW-1:0]     rpt_cnt;

  logic              same;
  logic              deb_done;
  logic              dly_done;
  logic              per_done;
  logic              push;
  evt_type_e         push_typ;
  key_evt_t          push_evt;
  key_evt_t          head;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

  assign same     = (key_q == cand);
  assign deb_done = (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign dly_done = (rpt_cnt == RW'(REPEAT_DELAY - 1));
  assign per_done = (rpt_cnt == RW'(REPEAT_PERIOD - 1));

  // Event generation is decoded from the current state so the push lands in
  // the FIFO on the same edge the FSM makes its decision.
  always_comb begin
    push     = 1'b0;
    push_typ = EVT_PRESS;
    unique case (state)
      DEBOUNCE: if (same && deb_done) push = 1'b1;
      HELD: if (same && dly_done) begin
        push     = 1'b1;
        push_typ = EVT_REPEAT;
      end
      REPEAT: if (same && per_done) begin
        push     = 1'b1;
        push_typ = EVT_REPEAT;
      end
      REL_DB: if (!same && deb_done) begin
        push     = 1'b1;
        push_typ = EVT_RELEASE;
      end
      default: ;
    endcase
  end

  assign push_evt = '{typ: push_typ, code: cand};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= '0;
      state   <= IDLE;
      cand    <= '0;
      cnt     <= '0;
      rpt_cnt <= '0;
    end else begin
      key_q <= key_code;
      case (state)
        IDLE: if (key_q != '0) begin
          cand  <= key_q;
          cnt   <= '0;
          state <= DEBOUNCE;
        end
        DEBOUNCE: begin
          if (same) begin
            if (deb_done) begin
              rpt_cnt <= '0;
              state   <= HELD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (key_q == '0) begin
            state <= IDLE;
          end else begin
            cand <= key_q;
            cnt  <= '0;
          end
        end
        HELD, REPEAT: begin
          if (!same) begin
            cnt   <= '0;
            state <= REL_DB;
          end else if ((state == HELD) ? dly_done : per_done) begin
            rpt_cnt <= '0;
            state   <= REPEAT;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
        end
        REL_DB: begin
          if (same) begin
            rpt_cnt <= '0;
            state   <= HELD;
          end else if (deb_done) begin
            if (key_q == '0) begin
              state <= IDLE;
            end else begin
              cand  <= key_q;
              cnt   <= '0;
              state <= DEBOUNCE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pop = evt_valid && evt_ready;

  kbd_event_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_evt),
    .pop   (pop),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_type  = head.typ;
  assign evt_code  = head.code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule
